// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_port_arbiter_pkg: shared state encoding and constants for the SDRAM port arbiter.
package sdram_port_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam logic [7:0] RDATA_ABORT = 8'hFF;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester, memory-side and status signals of the SDRAM port arbiter.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 23
);
  logic              p0_req, p0_we, p0_ack;
  logic [ADDR_W-1:0] p0_addr;
  logic [7:0]        p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_ack;
  logic [ADDR_W-1:0] p1_addr;
  logic [7:0]        p1_wdata, p1_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              timeout_err;
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata, mem_ack,
    output p0_rdata, p0_ack, p1_rdata, p1_ack, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata, mem_ack,
    input  p0_rdata, p0_ack, p1_rdata, p1_ack, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/arb_fair_pick.sv
// arb_fair_pick: fixed port-0 priority with a bounded run of port-0 grants while port 1 waits.
module arb_fair_pick #(
  parameter int MAX_P0_RUN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic p0_req,
  input  logic p1_req,
  input  logic decide,
  output logic win
);
  localparam logic [3:0] RUN_MAX = 4'(MAX_P0_RUN);
  logic [3:0] run_q, run_d;
  // win: 0 = port 0, 1 = port 1
  always_comb begin
    win = !p0_req || (p1_req && run_q == RUN_MAX);
    run_d = !decide ? run_q : (win || !p1_req) ? 4'd0 : run_q + 4'd1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) run_q <= 4'd0;
    else run_q <= run_d;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: sequences single-byte accesses from two requesters onto one SDRAM controller port,
// with a watchdog that aborts accesses the controller never acknowledges.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int MAX_P0_RUN = 4,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic reset_n,
  sdram_port_arbiter_if.slave bus
);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  state_e            state_q, state_d;
  logic              grant_q, grant_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d, terr_q, terr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d, p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic [7:0]        wd_q, wd_d, rd_val;
  logic              win, decide, finish;
  arb_fair_pick #(.MAX_P0_RUN(MAX_P0_RUN)) u_pick (
    .clk(clk), .reset_n(reset_n), .p0_req(bus.p0_req), .p1_req(bus.p1_req), .decide(decide), .win(win)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    wd_d = wd_q;
    terr_d = terr_q;
    decide = state_q == S_IDLE && (bus.p0_req || bus.p1_req);
    // an ack landing in the expiry cycle still counts as a normal completion
    finish = (state_q == S_ISSUE || state_q == S_WAIT) &&
             (bus.mem_ack || (state_q == S_WAIT && wd_q == WD_LAST));
    rd_val = bus.mem_ack ? bus.mem_rdata : RDATA_ABORT;
    case (state_q)
      S_IDLE: if (decide) begin
        grant_d = win;
        mem_we_d = win ? bus.p1_we : bus.p0_we;
        mem_addr_d = win ? bus.p1_addr : bus.p0_addr;
        mem_wdata_d = win ? bus.p1_wdata : bus.p0_wdata;
        mem_req_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE, S_WAIT: begin
        wd_d = state_q == S_WAIT ? wd_q + 8'd1 : 8'd0;
        state_d = finish ? S_DONE : S_WAIT;
        mem_req_d = !finish;
        terr_d = terr_q | (finish && !bus.mem_ack);
        p0_rdata_d = finish && !mem_we_q && grant_q == PORT_CPU ? rd_val : p0_rdata_q;
        p1_rdata_d = finish && !mem_we_q && grant_q == PORT_DMA ? rd_val : p1_rdata_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= PORT_CPU;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= 8'h00;
      p0_rdata_q <= 8'h00;
      p1_rdata_q <= 8'h00;
      wd_q <= 8'd0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      wd_q <= wd_d;
      terr_q <= terr_d;
    end
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;
  assign bus.p0_ack = state_q == S_DONE && grant_q == PORT_CPU;
  assign bus.p1_ack = state_q == S_DONE && grant_q == PORT_DMA;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed and randomized accesses against a transaction-level model of
// arbitration order, completion timing, read data and the sticky timeout flag.
module tb_sdram_port_arbiter;
  localparam int TO = 255;
  localparam int RUNMAX = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int streak = 0;
  logic [7:0] rd_m [2];
  logic terr_m = 1'b0;
  logic last_port;
  logic r [2];
  logic we [2];
  logic [22:0] ad [2];
  logic [7:0] wd [2];
  logic exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  sdram_port_arbiter_if #(.ADDR_W(23)) bus ();
  sdram_port_arbiter #(.ADDR_W(23), .MAX_P0_RUN(RUNMAX), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.p0_req = r[0]; bus.p0_we = we[0]; bus.p0_addr = ad[0]; bus.p0_wdata = wd[0];
    bus.p1_req = r[1]; bus.p1_we = we[1]; bus.p1_addr = ad[1]; bus.p1_wdata = wd[1];
  endtask

  task automatic setp(input int p, input logic rq, input logic w, input logic [22:0] a, input logic [7:0] d);
    r[p] = rq; we[p] = w; ad[p] = a; wd[p] = d;
    drive();
  endtask

  // Reference arbitration: port 0 first, except after RUNMAX port-0 wins in a row with port 1 waiting.
  task automatic pick(output logic w);
    w = (r[0] && !(r[1] && streak >= RUNMAX)) ? 1'b0 : 1'b1;
    streak = (!w && r[1]) ? streak + 1 : 0;
  endtask

  // lat = cycle (0 = the first mem_req cycle) in which mem_ack is returned; lat > TO means never.
  task automatic txn(input int lat, input logic [7:0] rd, input logic w, input bit drop);
    int k, seen, done_k;
    bit to;
    to = lat > TO;
    done_k = to ? TO + 1 : lat + 1;
    k = 0;
    while (!bus.mem_req && k < 8) begin @(negedge clk); k++; end
    chk("mem_req_rise", 32'(bus.mem_req), 1);
    chk("mem_we", 32'(bus.mem_we), 32'(we[w]));
    chk("mem_addr", 32'(bus.mem_addr), 32'(ad[w]));
    if (we[w]) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd[w]));
    else rd_m[w] = to ? 8'hFF : rd;
    terr_m = terr_m | to;
    k = 0;
    seen = -1;
    while (seen < 0 && k <= TO + 4) begin
      if (bus.p0_ack || bus.p1_ack) seen = k;
      else begin
        if (k == done_k - 1) chk("mem_req_held", 32'(bus.mem_req), 1);
        if (k == lat) begin bus.mem_ack = 1'b1; bus.mem_rdata = rd; end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'($urandom);
        k++;
      end
    end
    last_port = bus.p1_ack;
    chk("ack_cycle", seen, done_k);
    chk("ack_port", 32'(bus.p1_ack), 32'(w));
    chk("ack_both", 32'(bus.p0_ack & bus.p1_ack), 0);
    chk("mem_req_done", 32'(bus.mem_req), 0);
    chk("p0_rdata", 32'(bus.p0_rdata), 32'(rd_m[0]));
    chk("p1_rdata", 32'(bus.p1_rdata), 32'(rd_m[1]));
    chk("timeout_err", 32'(bus.timeout_err), 32'(terr_m));
    if (drop) begin r[w] = 1'b0; drive(); end
    @(negedge clk);
    chk("ack_pulse", 32'(bus.p0_ack | bus.p1_ack), 0);
  endtask

  initial begin
    logic w;
    int k;
    rd_m[0] = 8'h00;
    rd_m[1] = 8'h00;
    setp(0, 0, 0, 23'h0, 8'h0);
    setp(1, 0, 0, 23'h0, 8'h0);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 0);
    chk("rst_acks", 32'({bus.p0_ack, bus.p1_ack}), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    reset_n = 1'b1;
    @(negedge clk);
    // p0 read, ack three cycles after issue
    setp(0, 1, 0, 23'h100000, 8'h00);
    pick(w);
    txn(3, 8'h5A, w, 1);
    // p1 write leaves p1_rdata alone
    setp(1, 1, 1, 23'h000123, 8'hC3);
    pick(w);
    txn(2, 8'h11, w, 1);
    // both held continuously: port 1 gets a turn after four port-0 grants
    setp(0, 1, 0, 23'h000010, 8'h00);
    setp(1, 1, 0, 23'h200020, 8'h00);
    for (int i = 0; i < 10; i++) begin
      pick(w);
      txn(i % 3, 8'(i * 7 + 3), w, 0);
      chk("grant_order", 32'(last_port), 32'(exp_order[i]));
    end
    setp(0, 0, 0, 23'h0, 8'h0);
    setp(1, 0, 0, 23'h0, 8'h0);
    @(negedge clk);
    // ack exactly at watchdog expiry is a normal completion
    setp(0, 1, 0, 23'h7FFFFF, 8'h00);
    pick(w);
    txn(TO, 8'hA5, w, 1);
    // no ack at all on a p1 read: abort data and sticky error
    setp(1, 1, 0, 23'h055555, 8'h00);
    pick(w);
    txn(TO + 1000, 8'h00, w, 1);
    setp(0, 1, 1, 23'h012345, 8'h9E);
    pick(w);
    txn(1, 8'h00, w, 1);
    // stray ack in IDLE must be ignored
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h42;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("stray_mem_req", 32'(bus.mem_req), 0);
    chk("stray_acks", 32'({bus.p0_ack, bus.p1_ack}), 0);
    @(negedge clk);
    chk("stray_mem_req2", 32'(bus.mem_req), 0);
    chk("stray_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'({rd_m[0], rd_m[1]}));
    // randomized mix of requesters, directions, data and latencies
    repeat (40) begin
      for (int p = 0; p < 2; p++)
        setp(p, 1'($urandom), 1'($urandom), 23'($urandom), 8'($urandom));
      if (!r[0] && !r[1]) begin r[0] = 1'b1; drive(); end
      pick(w);
      txn(int'($urandom_range(0, 5)), 8'($urandom), w, 1);
      setp(0, 0, 0, 23'h0, 8'h0);
      setp(1, 0, 0, 23'h0, 8'h0);
      @(negedge clk);
    end
    // asynchronous reset while an access is waiting
    setp(0, 1, 0, 23'h0ABCDE, 8'h00);
    k = 0;
    while (!bus.mem_req && k < 8) begin @(negedge clk); k++; end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 0);
    chk("arst_acks", 32'({bus.p0_ack, bus.p1_ack}), 0);
    chk("arst_timeout_err", 32'(bus.timeout_err), 0);
    chk("arst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 0);
    streak = 0;
    rd_m[0] = 8'h00;
    rd_m[1] = 8'h00;
    terr_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    pick(w);
    txn(2, 8'h3C, w, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
